// File: rtl/uncached_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uncached_mem_ctrl
// Purpose  : Uncached load/store sequencer on an addr_ok/data_ok split bus;
//            optional posted write buffer enabled by UNCACHED_WBUF_EN.
// Revision : 1.0
// ============================================================================
module uncached_mem_ctrl #(
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_paddr,
  input  logic [3:0]  req_byteenable,
  input  logic [31:0] req_wrdata,
  input  logic        req_flush,
  input  logic        pipe_hold,
  output logic        stall,
  output logic [31:0] rddata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic        drain_op;
  logic        draining_flushed;
  logic        accept_blocking;
  logic        accept_posted;
  logic        issue_drain;
  logic        posted_held;
  logic [31:0] head_addr;
  logic [3:0]  head_be;
  logic [31:0] head_wdata;

  if (WBUF_DEPTH < 2 || (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_depth_check
    $error("WBUF_DEPTH must be a power of 2 and at least 2");
  end

`ifdef UNCACHED_WBUF_EN
  localparam int PTR_W = $clog2(WBUF_DEPTH);

  logic [31:0]    wb_addr  [WBUF_DEPTH];
  logic [3:0]     wb_be    [WBUF_DEPTH];
  logic [31:0]    wb_wdata [WBUF_DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           wb_empty;
  logic           wb_full;
  logic           wb_pop;

  assign wb_empty = (wr_ptr == rd_ptr);
  assign wb_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // A posted store already pushed but held in the stage must not be pushed twice.
  assign accept_posted   = req_valid & ~req_flush & req_write & ~wb_full &
                           (state != DONE) & ~posted_held;
  // Loads wait for the buffer to empty so they never overtake older stores.
  assign accept_blocking = (state == IDLE) & req_valid & ~req_flush & ~req_write & wb_empty;
  assign issue_drain     = (state == IDLE) & ~wb_empty;
  assign wb_pop          = (state == DATA) & bus_data_ok & drain_op;

  assign head_addr  = wb_addr[rd_ptr[PTR_W-1:0]];
  assign head_be    = wb_be[rd_ptr[PTR_W-1:0]];
  assign head_wdata = wb_wdata[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      posted_held <= 1'b0;
    end else begin
      if (accept_posted) wr_ptr <= wr_ptr + 1'b1;
      if (wb_pop)        rd_ptr <= rd_ptr + 1'b1;
      posted_held <= (accept_posted | posted_held) & pipe_hold;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_posted) begin
      wb_addr[wr_ptr[PTR_W-1:0]]  <= req_paddr;
      wb_be[wr_ptr[PTR_W-1:0]]    <= req_byteenable;
      wb_wdata[wr_ptr[PTR_W-1:0]] <= req_wrdata;
    end
  end
`else
  assign accept_posted   = 1'b0;
  assign accept_blocking = (state == IDLE) & req_valid & ~req_flush;
  assign issue_drain     = 1'b0;
  assign posted_held     = 1'b0;
  assign head_addr       = '0;
  assign head_be         = '0;
  assign head_wdata      = '0;
`endif

  assign stall = (req_valid & ~req_flush & (state != DONE) & ~accept_posted & ~posted_held) |
                 draining_flushed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      drain_op         <= 1'b0;
      draining_flushed <= 1'b0;
      bus_req          <= 1'b0;
      bus_wr           <= 1'b0;
      bus_addr         <= '0;
      bus_be           <= '0;
      bus_wdata        <= '0;
      rddata           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_blocking) begin
            state     <= ADDR;
            bus_req   <= 1'b1;
            drain_op  <= 1'b0;
            bus_wr    <= req_write;
            bus_addr  <= req_paddr;
            bus_be    <= req_byteenable;
            bus_wdata <= req_wrdata;
          end else if (issue_drain) begin
            state     <= ADDR;
            bus_req   <= 1'b1;
            drain_op  <= 1'b1;
            bus_wr    <= 1'b1;
            bus_addr  <= head_addr;
            bus_be    <= head_be;
            bus_wdata <= head_wdata;
          end
        end
        ADDR: begin
          if (req_flush && !drain_op) draining_flushed <= 1'b1;
          if (bus_addr_ok) begin
            state   <= DATA;
            bus_req <= 1'b0;
          end
        end
        DATA: begin
          if (bus_data_ok) begin
            draining_flushed <= 1'b0;
            // Killed accesses and buffer drains have no instruction waiting on them.
            if (drain_op || draining_flushed || req_flush) begin
              state <= IDLE;
            end else begin
              state <= DONE;
              if (!bus_wr) rddata <= bus_rdata;
            end
          end else if (req_flush && !drain_op) begin
            draining_flushed <= 1'b1;
          end
        end
        DONE: begin
          if (!pipe_hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uncached_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uncached_mem_ctrl
// Purpose  : Scoreboard bench for uncached_mem_ctrl (bus order, rddata, stall).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uncached_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_paddr = '0;
  logic [3:0]  req_byteenable = '0;
  logic [31:0] req_wrdata = '0;
  logic        req_flush = 1'b0;
  logic        pipe_hold = 1'b0;
  logic        stall;
  logic [31:0] rddata;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = '0;

  uncached_mem_ctrl #(.WBUF_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_paddr(req_paddr),
    .req_byteenable(req_byteenable), .req_wrdata(req_wrdata),
    .req_flush(req_flush), .pipe_hold(pipe_hold),
    .stall(stall), .rddata(rddata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_bus[$];
  logic [31:0] exp_rd[$];
  int          total = 0;
  int          bad = 0;
  int          req_cycles = 0;
  int          addr_delay = 0;
  int          data_delay = 0;
  int          acnt = 0;
  int          dcnt = 0;
  bit          in_data = 1'b0;
  bit          rd_pending = 1'b0;
  logic [31:0] next_rdata = '0;
  logic [31:0] last_rd = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus slave: addr_ok after addr_delay wait cycles, data_ok after data_delay more.
  always @(negedge clk) begin
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0BAD_0BAD;
    if (!rst_n) begin
      in_data = 1'b0; acnt = 0; dcnt = 0;
    end else begin
      if (in_data) begin
        if (dcnt >= data_delay) begin
          bus_data_ok = 1'b1; bus_rdata = next_rdata; in_data = 1'b0; dcnt = 0;
        end else dcnt++;
      end
      if (bus_req) begin
        if (acnt >= addr_delay) begin
          bus_addr_ok = 1'b1; in_data = 1'b1; acnt = 0;
        end else acnt++;
      end
    end
  end

  // Monitor: compares every bus request cycle and every read completion with the queues.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      rd_pending = 1'b0;
    end else begin
      if (rd_pending) begin
        rd_pending = 1'b0;
        if (exp_rd.size() == 0) begin
          total++; bad++;
          $display("FAIL rddata_unexpected: got %h expected none", rddata);
        end else check32("rddata", rddata, exp_rd.pop_front());
      end
      if (bus_req) begin
        req_cycles++;
        if (exp_bus.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_req_unexpected: got addr %h expected no request", bus_addr);
        end else begin
          check32("bus_wr",    {31'd0, bus_wr}, {31'd0, exp_bus[0].wr});
          check32("bus_addr",  bus_addr,        exp_bus[0].addr);
          check32("bus_be",    {28'd0, bus_be}, {28'd0, exp_bus[0].be});
          check32("bus_wdata", bus_wdata,       exp_bus[0].wdata);
          if (bus_addr_ok) void'(exp_bus.pop_front());
        end
      end
      if (bus_data_ok && !bus_wr) rd_pending = 1'b1;
    end
  end

  task automatic access(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] rd, input int exp_stall,
                        input int exp_req, input int hold, input int flush_cyc);
    int  n;
    int  r0;
    bit  done;
    n = 0; done = 1'b0;
    exp_bus.push_back('{wr, addr, be, wd});
    if (!wr) begin
      if (flush_cyc < 0) begin
        exp_rd.push_back(rd); last_rd = rd;
      end else exp_rd.push_back(last_rd);
    end
    next_rdata = rd;
    r0 = req_cycles;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_paddr = addr; req_byteenable = be;
    req_wrdata = wd; pipe_hold = (hold > 0);
    for (int c = 0; c < 200; c++) begin
      req_flush = (c == flush_cyc);
      if (flush_cyc >= 0 && c > flush_cyc) req_valid = 1'b0;
      #1;
      if (!stall && c > flush_cyc) begin
        done = 1'b1;
        break;
      end
      if (stall) n++;
      @(negedge clk);
    end
    req_flush = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL access_timeout: got stall stuck expected release addr %h", addr);
    end
    check32("stall_cycles", n, exp_stall);
    if (exp_req >= 0) check32("bus_req_cycles", req_cycles - r0, exp_req);
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      #1;
      check32("hold_stall", {31'd0, stall}, 32'd0);
      check32("hold_bus_req", {31'd0, bus_req}, 32'd0);
    end
    if (hold > 0) begin
      @(negedge clk);
      pipe_hold = 1'b0;
      #1;
      check32("hold_release_stall", {31'd0, stall}, 32'd0);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #3;
      if (exp_bus.size() == 0 && exp_rd.size() == 0 && !rd_pending) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain_timeout: got %0d bus txns pending expected 0", exp_bus.size());
    end
  endtask

  initial begin
    int st_exp;
    int st_req;
    repeat (2) @(negedge clk);
    #1;
    check32("rst_stall",     {31'd0, stall},   32'd0);
    check32("rst_bus_req",   {31'd0, bus_req}, 32'd0);
    check32("rst_bus_wr",    {31'd0, bus_wr},  32'd0);
    check32("rst_bus_addr",  bus_addr,         32'd0);
    check32("rst_bus_be",    {28'd0, bus_be},  32'd0);
    check32("rst_bus_wdata", bus_wdata,        32'd0);
    check32("rst_rddata",    rddata,           32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    access(1'b0, 32'h1FD0_0000, 4'hF, 32'h0, 32'hDEAD_BEEF, 3, 1, 0, -1);
    access(1'b0, 32'h1FD0_0004, 4'hF, 32'h0, 32'h1234_5678, 3, 1, 4, -1);
    addr_delay = 2; data_delay = 3;
    access(1'b0, 32'h1FD0_0008, 4'h3, 32'h0, 32'h5555_AAAA, 8, 3, 0, -1);
    addr_delay = 0; data_delay = 3;
    access(1'b0, 32'h1FD0_000C, 4'hF, 32'h0, 32'hCAFE_F00D, 5, 1, 0, 2);
    addr_delay = 0; data_delay = 0;
    access(1'b0, 32'h1FD0_0010, 4'hF, 32'h0, 32'h600D_F00D, 3, 1, 0, -1);

`ifdef UNCACHED_WBUF_EN
    st_exp = 0; st_req = -1;
`else
    st_exp = 3; st_req = 1;
`endif
    access(1'b1, 32'h1FD0_0014, 4'hC, 32'hA5A5_5A5A, 32'h0, st_exp, st_req, 0, -1);
    wait_idle();
    check32("store_keeps_rddata", rddata, last_rd);

`ifdef UNCACHED_WBUF_EN
    addr_delay = 6; data_delay = 0;
    for (int i = 0; i < 5; i++)
      access(1'b1, 32'hBFAF_0010 + 32'(i * 4), 4'hF, 32'h1111_1111 * 32'(i + 1), 32'h0,
             (i == 4) ? 6 : 0, -1, 0, -1);
    wait_idle();
    addr_delay = 1; data_delay = 1;
    access(1'b1, 32'hBFAF_0000, 4'hF, 32'h0123_4567, 32'h0, 0, -1, 0, -1);
    access(1'b0, 32'hBFAF_0000, 4'hF, 32'h0, 32'h89AB_CDEF, 10, -1, 0, -1);
    wait_idle();
`endif

    // Reset while the address phase is waiting: transaction dropped, outputs cleared.
    addr_delay = 5; data_delay = 0;
    exp_bus.push_back('{1'b0, 32'h1FD0_0020, 4'hF, 32'h0});
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_paddr = 32'h1FD0_0020;
    req_byteenable = 4'hF; req_wrdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #2;
    check32("midrst_bus_req",  {31'd0, bus_req}, 32'd0);
    check32("midrst_bus_addr", bus_addr,         32'd0);
    check32("midrst_rddata",   rddata,           32'd0);
    exp_bus.delete();
    exp_rd.delete();
    last_rd = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    addr_delay = 0;
    access(1'b0, 32'h1FD0_0030, 4'hF, 32'h0, 32'h7777_0001, 3, 1, 0, -1);
    wait_idle();
    check32("rd_queue_empty", exp_rd.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uncached_mem_ctrl.md
# uncached_mem_ctrl

Sequencer for uncached data accesses issued by the memory stage. It accepts one load or store per instruction, drives the external uncached bus with an addr_ok/data_ok split handshake, and stalls the pipeline until the access completes. It holds the returned word stable on `rddata`, which feeds the load-alignment and extension logic in the memory stage. An optional posted write buffer lets uncached stores retire without waiting for the bus.

## Interface
- `WBUF_DEPTH`, 4: posted write buffer entries (power of 2, ≥2); ignored without `UNCACHED_WBUF_EN`.

- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: memory stage holds a valid uncached access.
- `req_write` in 1: 1 = store, 0 = load.
- `req_paddr` in 32: physical address.
- `req_byteenable` in 4: byte lanes.
- `req_wrdata` in 32: store data.
- `req_flush` in 1: the instruction in the memory stage is killed.
- `pipe_hold` in 1: the pipeline is stalled by another unit, so the stage will not advance this cycle.
- `stall` out 1: freeze the memory stage.
- `rddata` out 32: load result; valid while in DONE.
- `bus_req` out 1: bus request.
- `bus_wr` out 1: bus write.
- `bus_addr` out 32: bus address.
- `bus_be` out 4: bus byte enables.
- `bus_wdata` out 32: bus write data.
- `bus_addr_ok` in 1: address accepted.
- `bus_data_ok` in 1: read data or write acknowledge.
- `bus_rdata` in 32: read data.

## Operation
- FSM states and transitions:
  - IDLE → ADDR: accepted access.
  - ADDR → DATA: `bus_req & bus_addr_ok`.
  - DATA → DONE: `bus_data_ok`.
  - DONE → IDLE: `!pipe_hold`.
- DONE holds while `pipe_hold`. This guarantees a held instruction is never re-issued.
- `bus_*` address, write, byte-enable and data outputs come from registers loaded on acceptance. They are stable from the first `bus_req` cycle until `bus_addr_ok`.
- `bus_req` = 1 only in ADDR.
- `rddata` is registered from `bus_rdata` on `bus_data_ok` of a read. It holds that value until the next read capture. It is not cleared on entry to IDLE.
- `stall` is combinational: `(req_valid & !req_flush & state∈{IDLE,ADDR,DATA} & !accept_posted) | draining_flushed`.
  - `accept_posted` is defined only with `UNCACHED_WBUF_EN`.
  - In DONE, `stall` = 0.
- Flush handling:
  - IDLE: the access is never issued.
  - ADDR or DATA: the bus transaction runs to `bus_data_ok`. It cannot be aborted.
  - After a flush in ADDR/DATA, `draining_flushed` is set, `stall` = 1 until `bus_data_ok`, and the result is discarded.
  - At `bus_data_ok` the FSM goes straight to IDLE; `rddata` is not updated.
- Only one outstanding bus transaction at a time.

## Timing
- Reset values:
  - `state` = IDLE.
  - `bus_req`, `bus_wr`, `stall` = 0.
  - `bus_addr`, `bus_be`, `bus_wdata`, `rddata` = 0.
  - Write buffer empty; `draining_flushed` = 0.
- Reset mid-transaction drops the transaction silently.
- Load with zero-wait bus:
  - Cycle 0: request seen, `stall` = 1.
  - Cycle 1: `bus_req`, `addr_ok` = 1.
  - Cycle 2: `data_ok`.
  - Cycle 3: DONE, `stall` = 0, `rddata` valid.
  - Minimum 3 stall cycles. Each extra wait cycle on addr_ok or data_ok adds one.
- Store without buffer: same timing as a load; `rddata` unchanged.
- `bus_addr_ok` and `bus_data_ok` are ignored outside ADDR and DATA respectively.

## Configuration
- `UNCACHED_WBUF_EN` defined: posted write buffer of `WBUF_DEPTH` entries holding {paddr, be, wdata}.
  - A store in IDLE with the buffer not full at the start of the cycle is pushed that cycle: `accept_posted` = 1, `stall` = 0, FSM stays IDLE.
  - The full check ignores a same-cycle pop.
  - If the buffer is full, the store stalls until an entry drains.
  - Whenever it is non-empty and the FSM is IDLE with no load accepted, the buffer issues its head entry through ADDR/DATA. It pops on `bus_data_ok`. Completion returns to IDLE, not DONE.
  - Loads are accepted only when the buffer is empty, so stores and loads stay in program order. Loads stall meanwhile.
  - Flush of a posted store after its push has no effect; the store is committed.
- `UNCACHED_WBUF_EN` not defined: no buffer; stores block exactly like loads.

## Test plan
- Load from `0x1FD0_0000`, `addr_ok` and `data_ok` immediate, `bus_rdata` = `0xDEADBEEF`:
  - `stall` high cycles 0–2.
  - `rddata` = `0xDEADBEEF` in cycle 3.
  - Exactly one `bus_req` cycle.
- Load completes while `pipe_hold` = 1 for 4 cycles: FSM stays in DONE, `stall` = 0, no second `bus_req`, then returns to IDLE.
- Load with `addr_ok` delayed 2 cycles and `data_ok` delayed 3:
  - `stall` lasts 8 cycles.
  - `bus_addr` and `bus_be` are stable throughout ADDR.
- `req_flush` asserted in DATA:
  - `stall` remains until `data_ok`.
  - `rddata` keeps its old value.
  - FSM returns to IDLE with no DONE cycle.
- `UNCACHED_WBUF_EN`, 5 back-to-back stores with the bus stalled (`addr_ok` = 0):
  - First 4 have `stall` = 0.
  - The 5th stalls until the first drain's `data_ok`.
  - Bus writes appear in program order.
- `UNCACHED_WBUF_EN`, store to `0xBFAF_0000` then load from the same address:
  - The load stalls until the store's `data_ok`.
  - The load's bus read issues after that, never before.
